// File: rtl/id_ex_if.sv
// ID/EX stage bundle: decoded operands/control from ID, forwarding sources
// from EX/MEM and MEM/WB, and the ALU-facing outputs of the stage.
interface id_ex_if #(parameter int W = 32, parameter int RA = 5);
  logic          stall, flush;
  logic          id_valid;
  logic [RA-1:0] id_rs, id_rt, id_rd;
  logic [W-1:0]  id_rs_data, id_rt_data, id_imm;
  logic          id_alusrc, id_regdst;
  logic [1:0]    id_aluop;
  logic [5:0]    id_funct;
  logic          id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic          exm_regwrite;
  logic [RA-1:0] exm_rd;
  logic [W-1:0]  exm_result;
  logic          mwb_regwrite;
  logic [RA-1:0] mwb_rd;
  logic [W-1:0]  mwb_result;
  logic [W-1:0]  alu_a, alu_b, ex_store_data;
  logic [2:0]    alu_mod;
  logic [RA-1:0] ex_dest;
  logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;
  logic          ex_illegal, load_use;

  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_alusrc, id_regdst, id_aluop, id_funct, id_regwrite,
           id_memread, id_memwrite, id_memtoreg, exm_regwrite, exm_rd,
           exm_result, mwb_regwrite, mwb_rd, mwb_result,
    input  alu_a, alu_b, alu_mod, ex_store_data, ex_dest, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal, load_use
  );

  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data,
           id_imm, id_alusrc, id_regdst, id_aluop, id_funct, id_regwrite,
           id_memread, id_memwrite, id_memtoreg, exm_regwrite, exm_rd,
           exm_result, mwb_regwrite, mwb_rd, mwb_result,
    output alu_a, alu_b, alu_mod, ex_store_data, ex_dest, ex_valid,
           ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal, load_use
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM > MEM/WB operand forwarding, ALU mode
// decode at capture, and load-use hazard detection for the ID stall logic.
module id_ex_fwd #(parameter int W = 32, parameter int RA = 5) (
  input  logic [RA-1:0] src,
  input  logic [W-1:0]  src_data,
  input  logic          exm_regwrite,
  input  logic [RA-1:0] exm_rd,
  input  logic [W-1:0]  exm_result,
  input  logic          mwb_regwrite,
  input  logic [RA-1:0] mwb_rd,
  input  logic [W-1:0]  mwb_result,
  output logic [W-1:0]  val
);
  // r0 is hardwired zero, so a producer targeting it must never be forwarded
  always_comb begin
    val = src_data;
    if (exm_regwrite && exm_rd == src && src != '0)      val = exm_result;
    else if (mwb_regwrite && mwb_rd == src && src != '0) val = mwb_result;
  end
endmodule

module id_ex_stage #(parameter int W = 32, parameter int RA = 5) (
  input  logic clk,
  input  logic rst,
  id_ex_if.slave bus
);
  typedef struct packed {
    logic          valid, regwrite, memread, memwrite, memtoreg, illegal, alusrc;
    logic [2:0]    mod;
    logic [RA-1:0] rs, rt, dest;
    logic [W-1:0]  rs_data, rt_data, imm;
  } ex_reg_t;

  function automatic ex_reg_t bubble();
    ex_reg_t b;
    b     = '0;
    b.mod = 3'b010;
    return b;
  endfunction

  ex_reg_t r, cap;
  logic [2:0] dec_mod;
  logic       dec_bad;

  always_comb begin
    dec_mod = 3'b010;
    dec_bad = 1'b0;
    case (bus.id_aluop)
      2'b00: dec_mod = 3'b010;
      2'b01: dec_mod = 3'b110;
      2'b11: dec_mod = 3'b001;
      default: begin
        case (bus.id_funct)
          6'b100000: dec_mod = 3'b010;
          6'b100010: dec_mod = 3'b110;
          6'b100100: dec_mod = 3'b000;
          6'b101010: dec_mod = 3'b111;
          6'b100101: dec_mod = 3'b001;
          default:   dec_bad = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    cap          = '0;
    cap.valid    = bus.id_valid;
    cap.regwrite = bus.id_regwrite;
    cap.memread  = bus.id_memread;
    cap.memwrite = bus.id_memwrite;
    cap.memtoreg = bus.id_memtoreg;
    cap.illegal  = dec_bad & bus.id_valid;
    cap.alusrc   = bus.id_alusrc;
    cap.mod      = dec_mod;
    cap.rs       = bus.id_rs;
    cap.rt       = bus.id_rt;
    cap.dest     = bus.id_regdst ? bus.id_rd : bus.id_rt;
    cap.rs_data  = bus.id_rs_data;
    cap.rt_data  = bus.id_rt_data;
    cap.imm      = bus.id_imm;
  end

  // flush outranks stall so a hazard bubble lands even while ID is held
  always_ff @(posedge clk) begin
    if (rst)              r <= bubble();
    else if (bus.flush)   r <= bubble();
    else if (!bus.stall)  r <= cap;
  end

  logic [1:0][RA-1:0] src;
  logic [1:0][W-1:0]  src_data, fwd;
  assign src      = {r.rt, r.rs};
  assign src_data = {r.rt_data, r.rs_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd #(.W(W), .RA(RA)) u_fwd (
      .src(src[g]), .src_data(src_data[g]),
      .exm_regwrite(bus.exm_regwrite), .exm_rd(bus.exm_rd), .exm_result(bus.exm_result),
      .mwb_regwrite(bus.mwb_regwrite), .mwb_rd(bus.mwb_rd), .mwb_result(bus.mwb_result),
      .val(fwd[g])
    );
  end

  assign bus.alu_a         = fwd[0];
  assign bus.alu_b         = r.alusrc ? r.imm : fwd[1];
  assign bus.ex_store_data = fwd[1];
  assign bus.alu_mod       = r.mod;
  assign bus.ex_dest       = r.dest;
  assign bus.ex_valid      = r.valid;
  assign bus.ex_regwrite   = r.regwrite;
  assign bus.ex_memread    = r.memread;
  assign bus.ex_memwrite   = r.memwrite;
  assign bus.ex_memtoreg   = r.memtoreg;
  assign bus.ex_illegal    = r.illegal;
  assign bus.load_use      = r.valid & r.memread & (r.dest != '0) &
                             ((r.dest == bus.id_rs) | (r.dest == bus.id_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// Scenario bench for id_ex_stage: decode table, forwarding priority,
// immediate/store path, load-use, stall/flush and mid-stream reset.
module tb_id_ex_stage;
  localparam int W = 32, RA = 5;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_if #(.W(W), .RA(RA)) bus();
  id_ex_stage #(.W(W), .RA(RA)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;

  typedef struct {
    logic [31:0] a, b, store;
    logic [2:0]  mod;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;
  exp_t sbq[$];

  function automatic logic [2:0] ref_mod(input logic [1:0] op, input logic [5:0] f, output logic bad);
    bad = 1'b0;
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    if (op == 2'b11) return 3'b001;
    if (f == 6'h20) return 3'b010;
    if (f == 6'h22) return 3'b110;
    if (f == 6'h24) return 3'b000;
    if (f == 6'h2a) return 3'b111;
    if (f == 6'h25) return 3'b001;
    bad = 1'b1;
    return 3'b010;
  endfunction

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
    bus.id_alusrc = 0; bus.id_regdst = 0; bus.id_aluop = '0; bus.id_funct = '0;
    bus.id_regwrite = 0; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
    bus.exm_regwrite = 0; bus.exm_rd = '0; bus.exm_result = '0;
    bus.mwb_regwrite = 0; bus.mwb_rd = '0; bus.mwb_result = '0;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] f,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                           input logic alusrc, input logic regdst);
    bus.id_valid = 1; bus.id_aluop = op; bus.id_funct = f;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
    bus.id_alusrc = alusrc; bus.id_regdst = regdst;
    bus.id_regwrite = 1; bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    repeat (2) begin
      @(negedge clk);
      set_instr(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
      bus.id_memread = 1;
      bus.exm_regwrite = 1; bus.exm_rd = 5'($urandom); bus.exm_result = $urandom;
    end
    @(negedge clk);
    n_chk++; if (bus.alu_a !== '0) begin n_fail++; $display("FAIL reset alu_a got %h exp 0", bus.alu_a); end
    n_chk++; if (bus.alu_b !== '0) begin n_fail++; $display("FAIL reset alu_b got %h exp 0", bus.alu_b); end
    n_chk++; if (bus.alu_mod !== 3'b010) begin n_fail++; $display("FAIL reset alu_mod got %b exp 010", bus.alu_mod); end
    n_chk++; if (bus.ex_store_data !== '0 || bus.ex_dest !== '0) begin n_fail++; $display("FAIL reset store/dest got %h/%h exp 0/0", bus.ex_store_data, bus.ex_dest); end
    n_chk++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_illegal} !== 6'b0)
      begin n_fail++; $display("FAIL reset ctrl got %b exp 000000", {bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_illegal}); end
    n_chk++; if (bus.load_use !== 1'b0) begin n_fail++; $display("FAIL reset load_use got %b exp 0", bus.load_use); end
    rst = 0;
    idle();
  endtask

  // one instruction per cycle, each expectation pushed at drive and popped a cycle later
  task automatic test_rtype();
    logic [5:0] fl [6] = '{6'h22, 6'h24, 6'h25, 6'h2a, 6'h20, 6'h00};
    logic [2:0] ml [6] = '{3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b010};
    logic       il [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_t e;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_chk++; if (bus.alu_a !== e.a) begin n_fail++; $display("FAIL rtype alu_a got %h exp %h", bus.alu_a, e.a); end
        n_chk++; if (bus.alu_b !== e.b) begin n_fail++; $display("FAIL rtype alu_b got %h exp %h", bus.alu_b, e.b); end
        n_chk++; if (bus.alu_mod !== e.mod) begin n_fail++; $display("FAIL rtype alu_mod got %b exp %b", bus.alu_mod, e.mod); end
        n_chk++; if (bus.ex_dest !== e.dest) begin n_fail++; $display("FAIL rtype ex_dest got %0d exp %0d", bus.ex_dest, e.dest); end
        n_chk++; if (bus.ex_illegal !== e.ill) begin n_fail++; $display("FAIL rtype ex_illegal got %b exp %b", bus.ex_illegal, e.ill); end
      end
      if (i < 6) begin
        set_instr(2'b10, fl[i], 5'd1, 5'd2, 5'd4, (i == 0) ? 32'd7 : $urandom,
                  (i == 0) ? 32'd3 : $urandom, 32'hDEAD, 1'b0, 1'b1);
        e.a = bus.id_rs_data; e.b = bus.id_rt_data; e.store = bus.id_rt_data;
        e.mod = ml[i]; e.dest = 5'd4; e.ill = il[i];
        sbq.push_back(e);
      end else idle();
    end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    idle();
    set_instr(2'b00, 6'h0, 5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 32'h0, 1'b0, 1'b0);
    bus.exm_regwrite = 1; bus.exm_rd = 5'd5; bus.exm_result = 32'h10;
    bus.mwb_regwrite = 1; bus.mwb_rd = 5'd5; bus.mwb_result = 32'h20;
    @(negedge clk);
    bus.id_valid = 0;
    n_chk++; if (bus.alu_a !== 32'h10) begin n_fail++; $display("FAIL fwd_exm alu_a got %h exp 10", bus.alu_a); end
    n_chk++; if (bus.alu_b !== 32'h66) begin n_fail++; $display("FAIL fwd_exm alu_b got %h exp 66", bus.alu_b); end
    bus.exm_regwrite = 0; #1;
    n_chk++; if (bus.alu_a !== 32'h20) begin n_fail++; $display("FAIL fwd_mwb alu_a got %h exp 20", bus.alu_a); end
    bus.mwb_regwrite = 0; #1;
    n_chk++; if (bus.alu_a !== 32'h55) begin n_fail++; $display("FAIL fwd_none alu_a got %h exp 55", bus.alu_a); end
    bus.exm_regwrite = 1; bus.exm_rd = 5'd6; bus.mwb_regwrite = 1; bus.mwb_rd = 5'd6; #1;
    n_chk++; if (bus.alu_b !== 32'h10 || bus.ex_store_data !== 32'h10)
      begin n_fail++; $display("FAIL fwd_rt alu_b/store got %h/%h exp 10/10", bus.alu_b, bus.ex_store_data); end
    set_instr(2'b00, 6'h0, 5'd0, 5'd0, 5'd7, 32'h99, 32'h77, 32'h0, 1'b0, 1'b0);
    bus.exm_rd = 5'd0; bus.mwb_rd = 5'd0;
    @(negedge clk);
    n_chk++; if (bus.alu_a !== 32'h99) begin n_fail++; $display("FAIL fwd_r0 alu_a got %h exp 99", bus.alu_a); end
    n_chk++; if (bus.alu_b !== 32'h77) begin n_fail++; $display("FAIL fwd_r0 alu_b got %h exp 77", bus.alu_b); end
    idle();
  endtask

  task automatic test_imm_store();
    @(negedge clk);
    idle();
    set_instr(2'b00, 6'h0, 5'd0, 5'd3, 5'd0, 32'h1, 32'h33, 32'hFFFFFFFC, 1'b1, 1'b0);
    bus.id_memwrite = 1; bus.id_regwrite = 0;
    bus.mwb_regwrite = 1; bus.mwb_rd = 5'd3; bus.mwb_result = 32'hAB;
    @(negedge clk);
    n_chk++; if (bus.alu_b !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL imm alu_b got %h exp fffffffc", bus.alu_b); end
    n_chk++; if (bus.ex_store_data !== 32'hAB) begin n_fail++; $display("FAIL imm store got %h exp ab", bus.ex_store_data); end
    n_chk++; if (bus.alu_mod !== 3'b010) begin n_fail++; $display("FAIL imm alu_mod got %b exp 010", bus.alu_mod); end
    n_chk++; if (bus.ex_memwrite !== 1'b1 || bus.ex_regwrite !== 1'b0)
      begin n_fail++; $display("FAIL imm ctrl got mw=%b rw=%b exp 1/0", bus.ex_memwrite, bus.ex_regwrite); end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    set_instr(2'b00, 6'h0, 5'd1, 5'd8, 5'd9, 32'h5, 32'h6, 32'h4, 1'b1, 1'b0);
    bus.id_memread = 1; bus.id_memtoreg = 1;
    @(negedge clk);
    set_instr(2'b10, 6'h20, 5'd8, 5'd2, 5'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    n_chk++; if (bus.load_use !== 1'b1 || bus.ex_dest !== 5'd8)
      begin n_fail++; $display("FAIL lu_rs load_use/dest got %b/%0d exp 1/8", bus.load_use, bus.ex_dest); end
    bus.id_rs = 5'd2; bus.id_rt = 5'd8; #1;
    n_chk++; if (bus.load_use !== 1'b1) begin n_fail++; $display("FAIL lu_rt load_use got %b exp 1", bus.load_use); end
    bus.id_rt = 5'd3; #1;
    n_chk++; if (bus.load_use !== 1'b0) begin n_fail++; $display("FAIL lu_nomatch load_use got %b exp 0", bus.load_use); end
    bus.stall = 1; bus.id_rs = 5'd8; #1;
    n_chk++; if (bus.load_use !== 1'b1) begin n_fail++; $display("FAIL lu_stall load_use got %b exp 1", bus.load_use); end
    bus.stall = 0; bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    n_chk++; if (bus.ex_valid !== 1'b0 || bus.load_use !== 1'b0)
      begin n_fail++; $display("FAIL lu_flush valid/load_use got %b/%b exp 0/0", bus.ex_valid, bus.load_use); end
    set_instr(2'b00, 6'h0, 5'd1, 5'd0, 5'd9, 32'h5, 32'h6, 32'h4, 1'b1, 1'b0);
    bus.id_memread = 1;
    @(negedge clk);
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_memread = 0; #1;
    n_chk++; if (bus.load_use !== 1'b0) begin n_fail++; $display("FAIL lu_r0 load_use got %b exp 0", bus.load_use); end
    idle();
  endtask

  task automatic test_stall_flush();
    @(negedge clk);
    idle();
    set_instr(2'b10, 6'h22, 5'd1, 5'd2, 5'd4, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_instr(2'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
      bus.stall = 1;
      @(negedge clk);
      n_chk++; if (bus.alu_a !== 32'h11 || bus.alu_b !== 32'h22 || bus.alu_mod !== 3'b110 || bus.ex_dest !== 5'd4 || bus.ex_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall hold got a=%h b=%h mod=%b dest=%0d v=%b exp 11/22/110/4/1", bus.alu_a, bus.alu_b, bus.alu_mod, bus.ex_dest, bus.ex_valid); end
    end
    bus.flush = 1;
    @(negedge clk);
    n_chk++; if (bus.ex_valid !== 1'b0 || bus.ex_regwrite !== 1'b0 || bus.alu_a !== '0 || bus.ex_dest !== '0)
      begin n_fail++; $display("FAIL stall_flush got v=%b rw=%b a=%h dest=%0d exp 0/0/0/0", bus.ex_valid, bus.ex_regwrite, bus.alu_a, bus.ex_dest); end
    idle();
    set_instr(2'b10, 6'h3f, 5'd1, 5'd2, 5'd4, 32'h1, 32'h2, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_chk++; if (bus.ex_illegal !== 1'b1 || bus.alu_mod !== 3'b010)
      begin n_fail++; $display("FAIL illegal got ill=%b mod=%b exp 1/010", bus.ex_illegal, bus.alu_mod); end
    bus.flush = 1;
    @(negedge clk);
    n_chk++; if (bus.ex_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_flush got %b exp 0", bus.ex_illegal); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [5:0] fts [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h11};
    exp_t e;
    logic bad;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_chk++; if (bus.alu_a !== e.a || bus.alu_b !== e.b || bus.ex_store_data !== e.store)
          begin n_fail++; $display("FAIL b2b operands got %h/%h/%h exp %h/%h/%h", bus.alu_a, bus.alu_b, bus.ex_store_data, e.a, e.b, e.store); end
        n_chk++; if (bus.alu_mod !== e.mod || bus.ex_dest !== e.dest || bus.ex_illegal !== e.ill)
          begin n_fail++; $display("FAIL b2b decode got %b/%0d/%b exp %b/%0d/%b", bus.alu_mod, bus.ex_dest, bus.ex_illegal, e.mod, e.dest, e.ill); end
      end
      if (i < 12) begin
        set_instr(2'($urandom_range(0, 3)), fts[$urandom_range(0, 6)], 5'($urandom), 5'($urandom),
                  5'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
        bus.id_valid = 1'($urandom);
        e.a = bus.id_rs_data;
        e.b = bus.id_alusrc ? bus.id_imm : bus.id_rt_data;
        e.store = bus.id_rt_data;
        e.dest = bus.id_regdst ? bus.id_rd : bus.id_rt;
        e.mod = ref_mod(bus.id_aluop, bus.id_funct, bad);
        e.ill = bad & bus.id_valid;
        sbq.push_back(e);
      end else idle();
    end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    set_instr(2'b01, 6'h0, 5'd3, 5'd4, 5'd5, 32'hAAAA, 32'hBBBB, 32'h0, 1'b0, 1'b1);
    bus.id_memread = 1;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle();
    n_chk++; if (bus.ex_valid !== 1'b0 || bus.ex_memread !== 1'b0 || bus.alu_mod !== 3'b010 || bus.alu_a !== '0)
      begin n_fail++; $display("FAIL mid_reset got v=%b mr=%b mod=%b a=%h exp 0/0/010/0", bus.ex_valid, bus.ex_memread, bus.alu_mod, bus.alu_a); end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_rtype();
    test_forwarding();
    test_imm_store();
    test_load_use();
    test_stall_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS-style datapath. It sits directly upstream of the ALU.
- Captures decoded operands and control from ID, resolves forwarding from EX/MEM and MEM/WB, and decodes aluop/funct into the 3-bit ALU mode.
- Drives the ALU a/b/mod inputs.
- Also produces the load-use hazard flag for the ID-stage stall logic.

Parameters:
- W, 32, datapath width
- RA, 5, register-address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers this cycle
- flush  in  1  load a bubble this cycle
- id_valid  in  1  ID holds a real instruction
- id_rs  in  RA  source register 1 number
- id_rt  in  RA  source register 2 number
- id_rd  in  RA  R-type destination number
- id_rs_data  in  W  register-file read data for rs
- id_rt_data  in  W  register-file read data for rt
- id_imm  in  W  sign-extended immediate
- id_alusrc  in  1  1 = ALU b from immediate
- id_regdst  in  1  1 = destination is rd, 0 = destination is rt
- id_aluop  in  2  00 add, 01 sub, 10 use funct, 11 or
- id_funct  in  6  R-type function field
- id_regwrite  in  1  instruction writes the register file
- id_memread  in  1  instruction is a load
- id_memwrite  in  1  instruction is a store
- id_memtoreg  in  1  writeback selects memory data
- exm_regwrite  in  1  EX/MEM stage writes the register file
- exm_rd  in  RA  EX/MEM destination register
- exm_result  in  W  EX/MEM ALU result
- mwb_regwrite  in  1  MEM/WB stage writes the register file
- mwb_rd  in  RA  MEM/WB destination register
- mwb_result  in  W  MEM/WB writeback value
- alu_a  out  W  ALU operand a
- alu_b  out  W  ALU operand b
- alu_mod  out  3  ALU mode
- ex_store_data  out  W  forwarded rt value, for stores
- ex_dest  out  RA  registered destination register
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  registered control bits
- ex_illegal  out  1  unsupported funct seen with aluop=10
- load_use  out  1  load-use hazard request to ID

Behaviour:
- Register update, evaluated each rising clk edge, priority rst > flush > stall > load:
  - rst: all registers cleared to 0. After reset every output is 0 except alu_mod = 010.
  - flush: bubble loaded (valid, regwrite, memread, memwrite, memtoreg, illegal all 0; fields 0). Flush overrides stall.
  - stall: every register holds its value.
  - load: capture all id_* inputs.
- Latency: fields captured at edge N are visible at the outputs after edge N. Forwarding is combinational off the registered rs/rt and the live exm_/mwb_ inputs.
- Destination is computed at capture: ex_dest = id_regdst ? id_rd : id_rt.
- ALU mode is decoded at capture and registered (alu_mod):
  - aluop 00 → 010 (add); aluop 01 → 110 (sub); aluop 11 → 001 (or).
  - aluop 10 with funct: 100000 → 010, 100010 → 110, 100100 → 000, 101010 → 111, 100101 → 001.
  - aluop 10 with any other funct → alu_mod 010 and ex_illegal = 1 (only if id_valid).
- Forwarding for operand A, sourced from registered rs; the same rule applies to rt:
  - if exm_regwrite and exm_rd == rs and rs != 0 → exm_result;
  - else if mwb_regwrite and mwb_rd == rs and rs != 0 → mwb_result;
  - else → registered rs data.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- alu_a = forwarded rs. ex_store_data = forwarded rt. alu_b = alusrc ? registered imm : forwarded rt.
- load_use = ex_valid & ex_memread & (ex_dest != 0) & ((ex_dest == id_rs) | (ex_dest == id_rt)). It is combinational and independent of stall.
- The external controller responds to load_use by asserting stall on the IF/ID stage and flush on this stage.
- Reset asserted mid-stream clears the stage on the next edge; no pending state survives.

Test Plan:
- Reset: rst=1 with random id_* inputs for 2 cycles → all outputs 0 except alu_mod=010; load_use=0.
- R-type sub: aluop=10, funct=100010, rs=1 data 7, rt=2 data 3, regdst=1, rd=4, no forwarding → next cycle alu_a=7, alu_b=3, alu_mod=110, ex_dest=4. Repeat with funct 100100/100101/101010 → 000/001/111. Funct 000000 → alu_mod=010, ex_illegal=1.
- Forwarding priority, captured rs=5:
  - exm_regwrite=1, exm_rd=5, exm_result=0x10 and mwb_regwrite=1, mwb_rd=5, mwb_result=0x20 → alu_a=0x10.
  - Drop exm_regwrite → alu_a=0x20.
  - Captured rs=0 with exm_rd=0 → alu_a=raw rs data.
- Immediate/store: aluop=00, alusrc=1, imm=0xFFFFFFFC, memwrite=1, rt=3 with mwb_rd=3, mwb_result=0xAB → alu_b=0xFFFFFFFC, ex_store_data=0xAB, alu_mod=010.
- Load-use: captured lw (memread=1, regdst=0, rt=8), then id_rs=8 → load_use=1. Assert flush → next cycle ex_valid=0, load_use=0. id_rs=0 with ex_dest=0 → load_use=0.
- Stall/flush: stall=1 for 3 cycles with changing id_* inputs → outputs frozen. Stall=1 with flush=1 → bubble loaded.
